// File: rtl/pc_seq_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encoding,
// AR source selects, opcode constants and register-reference bit positions.
// Optional build macro: PC_SEQ_INTERRUPT_EN adds the interrupt entry states.
package pc_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH_AR,
      S_FETCH_RD,
      S_DECODE,
      S_INDIRECT,
      S_BR_BUN,
      S_BSA_WR,
      S_BSA_JMP,
      S_EXEC,
      S_HALT
`ifdef PC_SEQ_INTERRUPT_EN
      , S_INT_AR
      , S_INT_WR
      , S_INT_INC
`endif
   } state_t;

   // AR source selects
   localparam logic [1:0] AR_SEL_PC   = 2'd0;
   localparam logic [1:0] AR_SEL_IR   = 2'd1;
   localparam logic [1:0] AR_SEL_MEM  = 2'd2;
   localparam logic [1:0] AR_SEL_ZERO = 2'd3;

   // Opcodes handled locally
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_REG = 3'd7;

   // Register-reference bit positions in IR[11:0]
   localparam int RR_HLT = 0;
   localparam int RR_SZE = 1;
   localparam int RR_SZA = 2;
   localparam int RR_SNA = 3;
   localparam int RR_SPA = 4;

   // I/O bit positions in IR[11:0]
   localparam int IO_IOF = 6;
   localparam int IO_ION = 7;

   // Memory-reference dispatch once the effective address is in AR
   function automatic state_t dispatch(input logic [2:0] op);
      case (op)
         OP_BUN:  return S_BR_BUN;
         OP_BSA:  return S_BSA_WR;
         default: return S_EXEC;
      endcase
   endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: walks PC/AR/IR and the memory port through
// fetch, decode, indirect and branch phases; other instructions are handed
// to the datapath over exec_start/exec_done.
// Optional build macro: PC_SEQ_INTERRUPT_EN (IEN flop, fgi/fgo, INT states).
module pc_sequencer #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              halted,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              mem_wsel,
   output logic              ar_load,
   output logic              ar_inc,
   output logic [1:0]        ar_sel,
   output logic              ir_load,
   output logic              pc_load,
   output logic              pc_inc,
   output logic              pc_clr,
   input  logic              ir_i,
   input  logic [2:0]        ir_op,
   input  logic [ADDR_W-1:0] ir_low,
   input  logic              ac_sign,
   input  logic              ac_zero,
   input  logic              e_zero,
   output logic              exec_start,
   input  logic              exec_done,
   input  logic              skip_req
`ifdef PC_SEQ_INTERRUPT_EN
   ,
   input  logic              fgi,
   input  logic              fgo,
   output logic              ien
`endif
);
   import pc_seq_pkg::*;

   // Register-reference bits decoded here (HLT and the four skips)
   localparam logic [ADDR_W-1:0] RR_KNOWN = ADDR_W'(32'h1F);

   state_t            state, next_state;
   logic              exec_started;
   logic              halt_armed;
   logic              skip_cond;
   logic [ADDR_W-1:0] rr_rest;

   assign skip_cond = (ir_low[RR_SPA] & ~ac_sign) | (ir_low[RR_SNA] & ac_sign) |
                      (ir_low[RR_SZA] & ac_zero)  | (ir_low[RR_SZE] & e_zero);
   assign rr_rest   = ir_low & ~RR_KNOWN;

`ifdef PC_SEQ_INTERRUPT_EN
   // ION/IOF are consumed here; anything else in an I/O word goes to EXEC
   localparam logic [ADDR_W-1:0] IO_KNOWN = ADDR_W'(32'hC0);
   logic              ien_q, ien_set, ien_clr;
   logic [ADDR_W-1:0] io_rest;
   assign io_rest = ir_low & ~IO_KNOWN;
   assign ien     = ien_q;

   // Interrupt enable flop; clear wins over set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ien_q <= 1'b0;
      else if (ien_clr) ien_q <= 1'b0;
      else if (ien_set) ien_q <= 1'b1;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // EXEC entry marker (exec_start only on the first EXEC cycle) and HALT
   // re-arm (run must be seen low before a rising level resumes)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_started <= 1'b0;
         halt_armed   <= 1'b0;
      end else begin
         exec_started <= (state == S_EXEC);
         halt_armed   <= (state == S_HALT) && (halt_armed || !run);
      end
   end

   // Next-state and control decode
   always_comb begin
      next_state = state;
      halted     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_wsel   = 1'b0;
      ar_load    = 1'b0;
      ar_inc     = 1'b0;
      ar_sel     = AR_SEL_PC;
      ir_load    = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_clr     = 1'b0;
      exec_start = 1'b0;
`ifdef PC_SEQ_INTERRUPT_EN
      ien_set    = 1'b0;
      ien_clr    = 1'b0;
`endif
      case (state)
         S_IDLE: if (run) next_state = S_FETCH_AR;
         S_FETCH_AR: begin
            if (!run) next_state = S_IDLE;
`ifdef PC_SEQ_INTERRUPT_EN
            else if (ien_q && (fgi || fgo)) next_state = S_INT_AR;
`endif
            else begin
               ar_load    = 1'b1;
               ar_sel     = AR_SEL_PC;
               next_state = S_FETCH_RD;
            end
         end
         S_FETCH_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_load    = 1'b1;
               pc_inc     = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            if (ir_op != OP_REG) begin
               ar_load    = 1'b1;
               ar_sel     = AR_SEL_IR;
               next_state = ir_i ? S_INDIRECT : dispatch(ir_op);
            end else if (!ir_i) begin
               if (ir_low[RR_HLT]) next_state = S_HALT;
               else begin
                  pc_inc     = skip_cond;
                  next_state = (|rr_rest) ? S_EXEC : S_FETCH_AR;
               end
            end else begin
`ifdef PC_SEQ_INTERRUPT_EN
               ien_set    = ir_low[IO_ION];
               ien_clr    = ir_low[IO_IOF];
               next_state = (|io_rest) ? S_EXEC : S_FETCH_AR;
`else
               next_state = S_EXEC;
`endif
            end
         end
         S_INDIRECT: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ar_load    = 1'b1;
               ar_sel     = AR_SEL_MEM;
               next_state = dispatch(ir_op);
            end
         end
         S_BR_BUN: begin
            pc_load    = 1'b1;
            next_state = S_FETCH_AR;
         end
         S_BSA_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               ar_inc     = 1'b1;
               next_state = S_BSA_JMP;
            end
         end
         S_BSA_JMP: begin
            pc_load    = 1'b1;
            next_state = S_FETCH_AR;
         end
         S_EXEC: begin
            exec_start = !exec_started;
            if (exec_done && exec_started) begin
               pc_inc     = skip_req;
               next_state = S_FETCH_AR;
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (halt_armed && run) next_state = S_FETCH_AR;
         end
`ifdef PC_SEQ_INTERRUPT_EN
         S_INT_AR: begin
            ar_load    = 1'b1;
            ar_sel     = AR_SEL_ZERO;
            next_state = S_INT_WR;
         end
         S_INT_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               pc_clr     = 1'b1;
               next_state = S_INT_INC;
            end
         end
         S_INT_INC: begin
            pc_inc     = 1'b1;
            ien_clr    = 1'b1;
            next_state = S_FETCH_AR;
         end
`endif
         default: next_state = S_IDLE;
      endcase
   end

endmodule
